axi_lite_arbiter: RTL and testbench
===================================

// Module: axi_lite_arbiter
// PURPOSE
// - N-master to 1-slave AXI4-Lite arbiter; sits directly upstream of the address-decoding crossbar.
// - Merges IFU/LSU (and any later masters) onto the single crossbar master port.
// - One transaction in flight at a time (read or write).
// - Winner owns the bus from address handshake until its R or B handshake completes.
// PARAMETERS
// - MASTER_NUM  2  number of upstream masters; index 0 = IFU, 1 = LSU
// PORTS
// - clk    input            1           clock; all logic on posedge
// - reset  input            1           synchronous, active-low reset (0 = in reset)
// - m      axi_lite_if.slave [MASTER_NUM]  upstream masters
// - s      axi_lite_if.master 1          downstream port, connects to crossbar master side
// BEHAVIOUR
// - State register, one-hot-free enum: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
// - Owner register: $clog2(MASTER_NUM) bits, min 1.
// - Request: req[i] = m[i].arvalid | m[i].awvalid.
// - IDLE:
//   - If any req, pick winner (see CONFIGURATION); latch owner.
//   - Go to RD_ADDR if winner's arvalid=1, else WR_ADDR. Read wins over write from the same master.
//   - 1-cycle arbitration bubble: no handshake completes in IDLE.
// - RD_ADDR:
//   - Drive s.arvalid = m[own].arvalid, s.araddr = m[own].araddr, m[own].arready = s.arready.
//   - On s.arvalid & s.arready -> RD_DATA.
// - RD_DATA:
//   - Drive s.rready = m[own].rready, m[own].rvalid = s.rvalid.
//   - On handshake -> IDLE; update round-robin pointer.
// - WR_ADDR:
//   - Forward aw signals as in RD_ADDR; on AW handshake -> WR_DATA.
//   - W is never forwarded before AW completes, even if wvalid is already high.
// - WR_DATA:
//   - Forward wvalid, wdata, wmask, wready between owner and s; on W handshake -> WR_RESP.
// - WR_RESP:
//   - Forward bvalid, bresp, bready; on B handshake -> IDLE; update round-robin pointer.
// - Broadcast: s.rdata, s.rresp, s.bresp go to every m[i].
// - Non-owner masters, and all masters in IDLE: arready, rvalid, awready, wready, bvalid = 0.
// - s valid/ready outputs are 0 in any state that does not forward them.
// - s.araddr, s.awaddr, s.wdata, s.wmask = 0 when not forwarding.
// - Reset (reset=0, checked at posedge):
//   - State = IDLE, owner = 0, RR pointer = MASTER_NUM-1.
//   - All valid/ready outputs 0 from the cycle after reset is sampled.
//   - Reset mid-transaction drops the transaction silently; masters are reset together with the arbiter.
// - Owner dropping arvalid/awvalid before handshake is a protocol violation.
//   - Lock is held regardless.
//   - Bench asserts it never happens.
// - Back-to-back: after a completing handshake the next grant is decided in the following IDLE cycle.
//   - Minimum spacing is 1 idle cycle between transactions.
// CONFIGURATION
// - ARB_RR_EN defined: round-robin.
//   - Search starts at (rr_ptr+1) mod MASTER_NUM.
//   - rr_ptr <= owner on transaction completion.
//   - Reset value MASTER_NUM-1, so master 0 wins first.
// - ARB_RR_EN undefined: fixed priority, lowest index wins.
//   - rr_ptr logic not instantiated.
// TESTING
// - Reset: hold reset=0 for 3 cycles with all m[i].arvalid=1 -> all arready/rvalid/s.arvalid = 0; state IDLE.
// - Single read: m[0] arvalid, araddr=0x80000000; s.arready=1 -> s.arvalid seen cycle+1.
//   - Slave returns rdata=0xDEADBEEF rresp=0 -> m[0].rvalid with that data; m[1].rvalid stays 0.
// - Contention: m[0], m[1] arvalid same cycle, repeated 4x.
//   - Fixed priority: m[1] served only after m[0] drops.
//   - ARB_RR_EN: grants 0,1,0,1.
// - Write: m[1] awaddr=0xA00003F8 with wdata=0x41, wmask=0x1 asserted together.
//   - s.wvalid rises only after s.aw handshake.
//   - bvalid reaches m[1] only; m[0] bvalid=0.
// - Same master arvalid+awvalid: read completes first, write granted after next IDLE cycle.
// - Reset in RD_DATA (s.rvalid pending) -> next cycle IDLE, all outputs 0.
//   - Subsequent m[1] read is granted and completes normally.

Source files
------------

// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite bus bundle shared by the arbiter's upstream masters and its
// downstream crossbar port.
interface axi_lite_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wmask;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wmask, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wmask, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// N-master to 1-slave AXI4-Lite arbiter, one transaction in flight.
// Define ARB_RR_EN for round-robin arbitration; otherwise fixed priority
// with the lowest master index winning.
module axi_lite_arbiter #(
  parameter int unsigned MASTER_NUM = 2
) (
  input  logic       clk,
  input  logic       reset,
  axi_lite_if.slave  m [MASTER_NUM],
  axi_lite_if.master s
);
  localparam int unsigned OW     = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   winner_c;

  logic [MASTER_NUM-1:0] req;
  logic [MASTER_NUM-1:0] m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
  logic [ADDR_W-1:0]     m_araddr [MASTER_NUM];
  logic [ADDR_W-1:0]     m_awaddr [MASTER_NUM];
  logic [DATA_W-1:0]     m_wdata  [MASTER_NUM];
  logic [STRB_W-1:0]     m_wmask  [MASTER_NUM];

  logic rd_done_c;
  logic b_done_c;

  // Flatten the master array and drive owner-gated responses back upstream.
  for (genvar g = 0; g < MASTER_NUM; g++) begin : g_m
    logic sel_c;
    assign sel_c        = (owner_q == OW'(g));
    assign m_arvalid[g] = m[g].arvalid;
    assign m_rready[g]  = m[g].rready;
    assign m_awvalid[g] = m[g].awvalid;
    assign m_wvalid[g]  = m[g].wvalid;
    assign m_bready[g]  = m[g].bready;
    assign m_araddr[g]  = m[g].araddr;
    assign m_awaddr[g]  = m[g].awaddr;
    assign m_wdata[g]   = m[g].wdata;
    assign m_wmask[g]   = m[g].wmask;
    assign req[g]       = m[g].arvalid | m[g].awvalid;

    assign m[g].arready = sel_c && (state_q == RD_ADDR) && s.arready;
    assign m[g].rvalid  = sel_c && (state_q == RD_DATA) && s.rvalid;
    assign m[g].awready = sel_c && (state_q == WR_ADDR) && s.awready;
    assign m[g].wready  = sel_c && (state_q == WR_DATA) && s.wready;
    assign m[g].bvalid  = sel_c && (state_q == WR_RESP) && s.bvalid;
    assign m[g].rdata   = s.rdata;
    assign m[g].rresp   = s.rresp;
    assign m[g].bresp   = s.bresp;
  end

  assign rd_done_c = (state_q == RD_DATA) && s.rvalid && m_rready[owner_q];
  assign b_done_c  = (state_q == WR_RESP) && s.bvalid && m_bready[owner_q];

`ifdef ARB_RR_EN
  logic [OW-1:0] rr_ptr_q, rr_ptr_d;

  // Round-robin pick: first requester above the pointer, else wrap to lowest.
  always_comb begin
    logic found;
    found    = 1'b0;
    winner_c = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (!found && req[i] && (OW'(i) > rr_ptr_q)) begin
        found    = 1'b1;
        winner_c = OW'(i);
      end
    end
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        winner_c = OW'(i);
      end
    end
  end

  // Pointer remembers the last master to complete a transaction.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (rd_done_c || b_done_c) rr_ptr_d = owner_q;
  end

  // Round-robin pointer register; master 0 is first after reset.
  always_ff @(posedge clk) begin
    if (!reset) rr_ptr_q <= OW'(MASTER_NUM - 1);
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  // Fixed priority pick: lowest requesting index wins.
  always_comb begin
    logic found;
    found    = 1'b0;
    winner_c = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        winner_c = OW'(i);
      end
    end
  end
`endif

  // Next-state: grant in IDLE, then hold the lock until R or B completes.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = winner_c;
          state_d = m_arvalid[winner_c] ? RD_ADDR : WR_ADDR;
        end
      end
      RD_ADDR: if (m_arvalid[owner_q] && s.arready) state_d = RD_DATA;
      RD_DATA: if (rd_done_c)                       state_d = IDLE;
      WR_ADDR: if (m_awvalid[owner_q] && s.awready) state_d = WR_DATA;
      WR_DATA: if (m_wvalid[owner_q] && s.wready)   state_d = WR_RESP;
      WR_RESP: if (b_done_c)                        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and owner registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Downstream forwarding from the owner; everything else parked at zero.
  always_comb begin
    s.arvalid = 1'b0;
    s.araddr  = '0;
    s.rready  = 1'b0;
    s.awvalid = 1'b0;
    s.awaddr  = '0;
    s.wvalid  = 1'b0;
    s.wdata   = '0;
    s.wmask   = '0;
    s.bready  = 1'b0;
    case (state_q)
      RD_ADDR: begin
        s.arvalid = m_arvalid[owner_q];
        s.araddr  = m_araddr[owner_q];
      end
      RD_DATA: s.rready = m_rready[owner_q];
      WR_ADDR: begin
        s.awvalid = m_awvalid[owner_q];
        s.awaddr  = m_awaddr[owner_q];
      end
      WR_DATA: begin
        s.wvalid = m_wvalid[owner_q];
        s.wdata  = m_wdata[owner_q];
        s.wmask  = m_wmask[owner_q];
      end
      WR_RESP: s.bready = m_bready[owner_q];
      default: ;
    endcase
  end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed self-checking bench for axi_lite_arbiter (2 masters).
module tb_axi_lite_arbiter;
  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  axi_lite_if m_if [2] ();
  axi_lite_if s_if ();

  axi_lite_arbiter #(.MASTER_NUM(2)) dut (
    .clk   (clk),
    .reset (reset),
    .m     (m_if),
    .s     (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ar(input int i, input logic v);
    if (i == 0) m_if[0].arvalid = v; else m_if[1].arvalid = v;
  endtask

  task automatic set_rr(input int i, input logic v);
    if (i == 0) m_if[0].rready = v; else m_if[1].rready = v;
  endtask

  function automatic logic get_rvalid(input int i);
    return (i == 0) ? m_if[0].rvalid : m_if[1].rvalid;
  endfunction

  function automatic logic [31:0] get_rdata(input int i);
    return (i == 0) ? m_if[0].rdata : m_if[1].rdata;
  endfunction

  // Master-side protocol monitor: an address valid may not drop before its ready.
  logic [1:0] ar_pend_q, aw_pend_q;
  always @(posedge clk) begin
    if (reset && ((ar_pend_q[0] && !m_if[0].arvalid) || (ar_pend_q[1] && !m_if[1].arvalid) ||
                  (aw_pend_q[0] && !m_if[0].awvalid) || (aw_pend_q[1] && !m_if[1].awvalid))) begin
      n_fail++;
      $error("FAIL protocol: address valid dropped before handshake ar=%b aw=%b", ar_pend_q, aw_pend_q);
    end
    if (!reset) begin
      ar_pend_q <= 2'b00;
      aw_pend_q <= 2'b00;
    end else begin
      ar_pend_q <= {m_if[1].arvalid & ~m_if[1].arready, m_if[0].arvalid & ~m_if[0].arready};
      aw_pend_q <= {m_if[1].awvalid & ~m_if[1].awready, m_if[0].awvalid & ~m_if[0].awready};
    end
  end

  // One read among possibly competing masters; checks who was granted.
  task automatic serve_read(input int exp, input logic rereq, input string tag);
    int who;
    who = -1;
    #1;
    for (int c = 0; c < 8; c++) begin
      if (m_if[0].arready) begin who = 0; break; end
      if (m_if[1].arready) begin who = 1; break; end
      tick();
    end
    chk({tag, "_grant"}, 32'(who), 32'(exp));
    if (who < 0) return;
    tick();
    if (!rereq) set_ar(who, 1'b0);
    s_if.rvalid = 1'b1;
    s_if.rdata  = 32'h1000 + 32'(who);
    set_rr(who, 1'b1);
    #1;
    chk({tag, "_rvalid"}, 32'(get_rvalid(who)), 32'd1);
    chk({tag, "_rdata"}, get_rdata(who), 32'h1000 + 32'(who));
    tick();
    s_if.rvalid = 1'b0;
    set_rr(who, 1'b0);
  endtask

  initial begin
    int exp_grant [5];
    logic rereq [5];
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        m_if[0].arvalid = 1'b0; m_if[0].araddr = '0; m_if[0].rready = 1'b0;
        m_if[0].awvalid = 1'b0; m_if[0].awaddr = '0; m_if[0].wvalid = 1'b0;
        m_if[0].wdata = '0; m_if[0].wmask = '0; m_if[0].bready = 1'b0;
      end else begin
        m_if[1].arvalid = 1'b0; m_if[1].araddr = '0; m_if[1].rready = 1'b0;
        m_if[1].awvalid = 1'b0; m_if[1].awaddr = '0; m_if[1].wvalid = 1'b0;
        m_if[1].wdata = '0; m_if[1].wmask = '0; m_if[1].bready = 1'b0;
      end
    end
    s_if.arready = 1'b1; s_if.rvalid = 1'b0; s_if.rdata = '0; s_if.rresp = '0;
    s_if.awready = 1'b0; s_if.wready = 1'b0; s_if.bvalid = 1'b0; s_if.bresp = '0;

    // Reset held with both masters requesting: nothing is granted.
    m_if[0].arvalid = 1'b1;
    m_if[1].arvalid = 1'b1;
    repeat (3) tick();
    chk("rst_m0_arready", 32'(m_if[0].arready), 32'd0);
    chk("rst_m1_arready", 32'(m_if[1].arready), 32'd0);
    chk("rst_m0_rvalid",  32'(m_if[0].rvalid),  32'd0);
    chk("rst_m1_rvalid",  32'(m_if[1].rvalid),  32'd0);
    chk("rst_s_arvalid",  32'(s_if.arvalid),    32'd0);
    m_if[0].arvalid = 1'b0;
    m_if[1].arvalid = 1'b0;
    reset = 1'b1;
    tick();

    // Single read from master 0.
    m_if[0].arvalid = 1'b1;
    m_if[0].araddr  = 32'h8000_0000;
    #1;
    chk("rd_idle_bubble", 32'(s_if.arvalid), 32'd0);
    tick();
    chk("rd_s_arvalid",   32'(s_if.arvalid),    32'd1);
    chk("rd_s_araddr",    s_if.araddr,          32'h8000_0000);
    chk("rd_m0_arready",  32'(m_if[0].arready), 32'd1);
    chk("rd_m1_arready",  32'(m_if[1].arready), 32'd0);
    tick();
    m_if[0].arvalid = 1'b0;
    m_if[0].rready  = 1'b1;
    s_if.rvalid = 1'b1;
    s_if.rdata  = 32'hDEAD_BEEF;
    s_if.rresp  = 2'd0;
    #1;
    chk("rd_s_arvalid_off", 32'(s_if.arvalid),    32'd0);
    chk("rd_s_araddr_off",  s_if.araddr,          32'd0);
    chk("rd_s_rready",      32'(s_if.rready),     32'd1);
    chk("rd_m0_rvalid",     32'(m_if[0].rvalid),  32'd1);
    chk("rd_m0_rdata",      m_if[0].rdata,        32'hDEAD_BEEF);
    chk("rd_m0_rresp",      32'(m_if[0].rresp),   32'd0);
    chk("rd_m1_rvalid",     32'(m_if[1].rvalid),  32'd0);
    tick();
    s_if.rvalid = 1'b0;
    m_if[0].rready = 1'b0;
    #1;
    chk("rd_done_m0_rvalid", 32'(m_if[0].rvalid), 32'd0);

    // Contention: fresh reset so both arbitration modes start from master 0.
    reset = 1'b0;
    tick();
    reset = 1'b1;
`ifdef ARB_RR_EN
    exp_grant = '{0, 1, 0, 1, 0};
`else
    exp_grant = '{0, 0, 0, 0, 1};
`endif
    rereq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    m_if[0].arvalid = 1'b1;
    m_if[1].arvalid = 1'b1;
    m_if[0].araddr  = 32'h0000_1000;
    m_if[1].araddr  = 32'h0000_2000;
    for (int t = 0; t < 5; t++) begin
      serve_read(exp_grant[t], rereq[t], $sformatf("cont%0d", t));
    end
    chk("cont_drained_m0", 32'(m_if[0].arvalid | m_if[1].arvalid), 32'd0);

    // Write from master 1 with AW and W presented together.
    s_if.awready = 1'b1;
    s_if.wready  = 1'b1;
    m_if[1].awvalid = 1'b1;
    m_if[1].awaddr  = 32'hA000_03F8;
    m_if[1].wvalid  = 1'b1;
    m_if[1].wdata   = 32'h0000_0041;
    m_if[1].wmask   = 4'h1;
    #1;
    chk("wr_idle_wvalid", 32'(s_if.wvalid), 32'd0);
    tick();
    chk("wr_s_awvalid",    32'(s_if.awvalid),    32'd1);
    chk("wr_s_awaddr",     s_if.awaddr,          32'hA000_03F8);
    chk("wr_s_wvalid_pre", 32'(s_if.wvalid),     32'd0);
    chk("wr_m1_awready",   32'(m_if[1].awready), 32'd1);
    chk("wr_m1_wready_pre",32'(m_if[1].wready),  32'd0);
    tick();
    m_if[1].awvalid = 1'b0;
    #1;
    chk("wr_s_wvalid",  32'(s_if.wvalid),    32'd1);
    chk("wr_s_wdata",   s_if.wdata,          32'h0000_0041);
    chk("wr_s_wmask",   32'(s_if.wmask),     32'h1);
    chk("wr_m1_wready", 32'(m_if[1].wready), 32'd1);
    chk("wr_m0_wready", 32'(m_if[0].wready), 32'd0);
    tick();
    m_if[1].wvalid = 1'b0;
    m_if[1].bready = 1'b1;
    s_if.bvalid = 1'b1;
    s_if.bresp  = 2'd0;
    #1;
    chk("wr_s_wdata_off", s_if.wdata,          32'd0);
    chk("wr_s_bready",    32'(s_if.bready),    32'd1);
    chk("wr_m1_bvalid",   32'(m_if[1].bvalid), 32'd1);
    chk("wr_m0_bvalid",   32'(m_if[0].bvalid), 32'd0);
    tick();
    s_if.bvalid = 1'b0;
    m_if[1].bready = 1'b0;
    #1;
    chk("wr_done_m1_bvalid", 32'(m_if[1].bvalid), 32'd0);

    // Same master requests read and write together: read first.
    m_if[0].arvalid = 1'b1;
    m_if[0].araddr  = 32'h0000_0100;
    m_if[0].awvalid = 1'b1;
    m_if[0].awaddr  = 32'h0000_0200;
    m_if[0].wvalid  = 1'b1;
    m_if[0].wdata   = 32'h1234_5678;
    m_if[0].wmask   = 4'hF;
    tick();
    chk("rw_s_arvalid", 32'(s_if.arvalid), 32'd1);
    chk("rw_s_awvalid", 32'(s_if.awvalid), 32'd0);
    tick();
    m_if[0].arvalid = 1'b0;
    m_if[0].rready  = 1'b1;
    s_if.rvalid = 1'b1;
    #1;
    chk("rw_m0_rvalid", 32'(m_if[0].rvalid), 32'd1);
    tick();
    s_if.rvalid = 1'b0;
    m_if[0].rready = 1'b0;
    #1;
    chk("rw_idle_awvalid", 32'(s_if.awvalid), 32'd0);
    tick();
    chk("rw_s_awvalid", 32'(s_if.awvalid), 32'd1);
    chk("rw_s_awaddr",  s_if.awaddr,       32'h0000_0200);
    tick();
    m_if[0].awvalid = 1'b0;
    #1;
    chk("rw_s_wvalid", 32'(s_if.wvalid), 32'd1);
    chk("rw_s_wdata",  s_if.wdata,       32'h1234_5678);
    tick();
    m_if[0].wvalid = 1'b0;
    m_if[0].bready = 1'b1;
    s_if.bvalid = 1'b1;
    #1;
    chk("rw_m0_bvalid", 32'(m_if[0].bvalid), 32'd1);
    tick();
    s_if.bvalid = 1'b0;
    m_if[0].bready = 1'b0;

    // Reset while a read response is pending.
    m_if[0].arvalid = 1'b1;
    m_if[0].araddr  = 32'h0000_0300;
    tick();
    tick();
    m_if[0].arvalid = 1'b0;
    s_if.rvalid = 1'b1;
    #1;
    chk("rst_mid_rvalid_pre", 32'(m_if[0].rvalid), 32'd1);
    reset = 1'b0;
    tick();
    chk("rst_mid_m0_rvalid", 32'(m_if[0].rvalid), 32'd0);
    chk("rst_mid_s_rready",  32'(s_if.rready),    32'd0);
    chk("rst_mid_s_arvalid", 32'(s_if.arvalid),   32'd0);
    reset = 1'b1;
    s_if.rvalid = 1'b0;
    m_if[1].arvalid = 1'b1;
    m_if[1].araddr  = 32'h0000_0400;
    serve_read(1, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
